// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute pipe: S1 captures ctrl/operands, S2 holds result and flags.
// Latency: 2 cycles from acceptance to out_valid; one op per cycle when out_ready is held high.
// Backpressure: valid/ready per stage; in_ready is derived from out_ready and stage valids only, and S2 holds while stalled.
module alu_exec_pipe #(
  parameter int DATA_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;
    logic              illegal;
  } res_t;

  logic             s1_valid;
  op_t              s1_op;
  logic             s2_valid;
  res_t             s2_res;
  res_t             res_d;
  logic             s1_adv;
  logic             s2_adv;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic             a_msb;
  logic             b_msb;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid;
  assign result    = s2_res.result;
  assign zero      = s2_res.zero;
  assign overflow  = s2_res.overflow;
  assign illegal   = s2_res.illegal;

  assign sum   = s1_op.a + s1_op.b;
  assign diff  = s1_op.a - s1_op.b;
  assign a_msb = s1_op.a[DATA_W-1];
  assign b_msb = s1_op.b[DATA_W-1];

  // Result and flags for the op sitting in S1; zero always follows the final result.
  always_comb begin
    res_d = '0;
    case (s1_op.ctrl)
      ALU_AND: res_d.result = s1_op.a & s1_op.b;
      ALU_OR:  res_d.result = s1_op.a | s1_op.b;
      ALU_NOR: res_d.result = ~(s1_op.a | s1_op.b);
      ALU_ADD: begin
        res_d.result   = sum;
        res_d.overflow = (a_msb == b_msb) && (sum[DATA_W-1] != a_msb);
      end
      ALU_SUB: begin
        res_d.result   = diff;
        res_d.overflow = (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
      end
      ALU_SLT: res_d.result = {{(DATA_W-1){1'b0}}, ($signed(s1_op.a) < $signed(s1_op.b))};
      default: res_d.illegal = 1'b1;
    endcase
    res_d.zero = (res_d.result == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op.ctrl <= alu_ctrl;
        s1_op.a    <= op_a;
        s1_op.b    <= op_b;
      end
    end
  end

  // S2 only reloads when S1 carries an op, so a stalled or drained output keeps its last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= res_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (s2_adv && s1_valid && res_d.illegal && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: hand-computed vectors checked with immediate assertions.
module tb_alu_exec_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  alu_exec_pipe #(.DATA_W(32), .ERR_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic z, input logic ov, input logic il);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    op_a      = '0;
    op_b      = '0;

    // Reset state
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);

    // ADD overflow, two-cycle latency
    out_ready = 1'b1;
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    in_valid = 1'b0;
    chk("add.lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk("add.drain_valid", 32'(out_valid), 32'd0);

    // SUB then SLT back-to-back
    send(4'b0110, 32'd5, 32'd5);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1);
    in_valid = 1'b0;
    chk_out("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("slt.drain_valid", 32'(out_valid), 32'd0);

    // Bitwise ops, SUB overflow and SLT false, streamed one per cycle
    send(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF);
    send(4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF);
    chk_out("nor", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF);
    chk_out("and", 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 32'h8000_0000, 32'h0000_0001);
    chk_out("or", 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("slt_false", 32'd0, 1'b1, 1'b0, 1'b0);
    tick();

    // Back-pressure: two ops fill the pipe, third waits
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2);
    chk("bp.in_ready_1", 32'(in_ready), 32'd1);
    send(4'b0010, 32'd10, 32'd20);
    chk("bp.in_ready_2", 32'(in_ready), 32'd0);
    chk_out("bp.hold0", 32'd3, 1'b0, 1'b0, 1'b0);
    alu_ctrl = 4'b0001;
    op_a     = 32'h0000_00F0;
    op_b     = 32'h0000_000F;
    tick();
    chk("bp.in_ready_3", 32'(in_ready), 32'd0);
    chk_out("bp.hold1", 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("bp.hold2", 32'd3, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.op2", 32'd30, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("bp.op3", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp.drain_valid", 32'(out_valid), 32'd0);

    // Illegal code and saturating error counter
    send(4'b1111, 32'h0000_FFFF, 32'h0000_FFFF);
    in_valid = 1'b0;
    chk("ill.err_before", 32'(err_count), 32'd0);
    tick();
    chk_out("ill", 32'd0, 1'b1, 1'b0, 1'b1);
    chk("ill.err_after", 32'(err_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? 4'b1111 : 4'b0011, 32'(i), 32'hFFFF_FFFF);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("ill.err_sat", 32'(err_count), 32'd255);
    send(4'b0000, 32'hFFFF_FFFF, 32'h1234_5678);
    in_valid = 1'b0;
    tick();
    chk_out("legal_after_ill", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    chk("ill.err_hold", 32'(err_count), 32'd255);

    // Reset between edges with both stages full
    out_ready = 1'b0;
    send(4'b0010, 32'd100, 32'd1);
    send(4'b0010, 32'd200, 32'd2);
    in_valid = 1'b0;
    chk("mid.full_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.err_count", 32'(err_count), 32'd0);
    chk("mid.result", result, 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid.no_ghost", 32'(out_valid), 32'd0);
    end
    chk("mid.err_final", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width in bits.
REQ-002 Parameter: ERR_W, 8, width of illegal-operation counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 alu_ctrl  input  4  operation code from ALU decoder.
REQ-008 op_a  input  DATA_W  first operand (rs).
REQ-009 op_b  input  DATA_W  second operand (rt).
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 result  output  DATA_W  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 overflow  output  1  signed overflow (add/sub only).
REQ-015 illegal  output  1  accepted code was not a legal ALU code.
REQ-016 err_count  output  ERR_W  saturating count of illegal codes delivered.

Function
REQ-017 Legal codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all others illegal.
REQ-018 Two register stages SHALL exist: S1 (captured ctrl/operands + valid), S2 (computed result/flags + valid).
REQ-019 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-020 S2 advance condition: s2_adv = !s2_valid || out_ready; S1 advance condition: s1_adv = !s1_valid || s2_adv.
REQ-021 in_ready SHALL equal s1_adv (combinational from out_ready and stage valids; no combinational path from in_valid).
REQ-022 Latency SHALL be 2 cycles: op accepted at edge N appears with out_valid=1 after edge N+1, with no back-pressure.
REQ-023 Throughput SHALL be one op per cycle when out_ready held high.
REQ-024 While out_valid=1 and out_ready=0, result, zero, overflow, illegal SHALL hold stable.
REQ-025 When s2_adv and S1 empty, S2 SHALL become empty (out_valid=0).
REQ-026 ADD/SUB SHALL be modulo 2^DATA_W; overflow=1 iff operand signs (b inverted for SUB) agree and result sign differs.
REQ-027 SLT SHALL return 1 if op_a < op_b signed, else 0; overflow=0.
REQ-028 AND/OR/NOR SHALL be bitwise; overflow=0.
REQ-029 Illegal code SHALL produce result=0, zero=1, overflow=0, illegal=1.
REQ-030 zero SHALL be computed from the final result in every case.
REQ-031 err_count SHALL increment by 1 on the edge an illegal op enters S2; saturate at 2^ERR_W-1.
REQ-032 Operations SHALL be delivered in acceptance order; none dropped or duplicated.

Reset
REQ-033 Reset asserted SHALL immediately force out_valid=0, S1/S2 valid=0, result=0, zero=0, overflow=0, illegal=0, err_count=0.
REQ-034 in_ready SHALL be 1 during reset-held and first post-reset cycle with out_ready don't-care.
REQ-035 Reset mid-operation SHALL discard in-flight ops; none emerge after release.

Verification
REQ-036 ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> two cycles later result=0x80000000, overflow=1, zero=0.
REQ-037 SUB 5 - 5, then SLT 0xFFFFFFFF vs 1 back-to-back -> result 0/zero=1, then result 1, consecutive cycles.
REQ-038 Three ops streamed, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, output held stable, all 3 emerge in order once out_ready=1.
REQ-039 alu_ctrl=1111 with op_a=op_b=0xFFFF -> result=0, illegal=1, zero=1, err_count 0->1; 300 illegal ops -> err_count=255.
REQ-040 NOR 0x0F0F0F0F, 0x00FF00FF -> result=0xF000F000; AND/OR same operands -> 0x000F000F / 0x0FFF0FFF.
REQ-041 Reset asserted between edges with both stages full -> out_valid=0 immediately, nothing delivered after release, err_count=0.
